bg_fetch_sequencer: RTL and testbench

Parametrised per-scanline background fetch scheduler for the tile video pipeline. It generates memory-access strobes for several background layers per tile slot: char-map address/data, palette address/data, tile-low and tile-high plane address/data. It also generates the pixel-shift enable. It adds a memory-grant stall handshake, per-layer enable and fine pan, and a line-done pulse. It sits between line timing (line_start) and the shared video memory arbiter / per-layer pixel shifters.

---
 rtl/bg_fetch_sequencer.sv | 112 +++++++++++
 tb/tb_bg_fetch_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_fetch_sequencer.sv
// Per-scanline background fetch scheduler: memory strobes per layer
// and pixel-shift enable for each tile slot, stalled by the arbiter grant.
module bg_fetch_sequencer #(
    parameter int SLOT_LEN       = 12,
    parameter int TILES_PER_LINE = 40,
    parameter int LAYERS         = 2,
    parameter int PAN_BITS       = 3,
    parameter int TILE_IDX_W     = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       line_start,
    input  logic [LAYERS*PAN_BITS-1:0] pan_offset,
    input  logic [LAYERS-1:0]          layer_enable,
    input  logic                       mem_grant,
    output logic [LAYERS-1:0]          char_addr_out,
    output logic [LAYERS-1:0]          char_data_in,
    output logic [LAYERS-1:0]          pal_addr_out,
    output logic [LAYERS-1:0]          pal_data_in,
    output logic [LAYERS-1:0]          tile_lo_addr_out,
    output logic [LAYERS-1:0]          tile_lo_data_in,
    output logic [LAYERS-1:0]          tile_hi_addr_out,
    output logic [LAYERS-1:0]          tile_hi_data_in,
    output logic                       pixel_out,
    output logic [TILE_IDX_W-1:0]      tile_index,
    output logic                       busy,
    output logic                       line_done
);

    localparam int PIX_PER_TILE = 2 ** PAN_BITS;
    localparam int POS_W        = $clog2(SLOT_LEN);

    logic                  live;
    logic [POS_W-1:0]      pos;
    logic [TILE_IDX_W-1:0] tileIdx;
    logic [TILE_IDX_W-1:0] lastTile;
    logic [LAYERS-1:0]     enLatched;
    logic                  extraSlot;
    logic                  lineDoneQ;
    logic                  advance;
    logic                  slotEnd;
    logic                  lineEnd;
    logic                  panAny;

    // A panned enabled layer needs one more tile to cover the partial edge
    always_comb begin
        panAny = 1'b0;
        for (int l = 0; l < LAYERS; l++) begin
            if (layer_enable[l] &&
                pan_offset[l*PAN_BITS +: PAN_BITS] != '0) begin
                panAny = 1'b1;
            end
        end
    end

    assign advance  = live & mem_grant;
    assign slotEnd  = (pos == POS_W'(SLOT_LEN - 1));
    assign lastTile = TILE_IDX_W'(TILES_PER_LINE - 1)
                    + TILE_IDX_W'(extraSlot);
    assign lineEnd  = advance & slotEnd & (tileIdx == lastTile);

    always_ff @(posedge clk) begin
        if (reset) begin
            live      <= 1'b0;
            pos       <= '0;
            tileIdx   <= '0;
            enLatched <= '0;
            extraSlot <= 1'b0;
            lineDoneQ <= 1'b0;
        end else begin
            lineDoneQ <= lineEnd & ~line_start;
            if (line_start) begin
                live      <= 1'b1;
                pos       <= '0;
                tileIdx   <= '0;
                enLatched <= layer_enable;
                extraSlot <= panAny;
            end else if (advance) begin
                if (slotEnd) begin
                    pos     <= '0;
                    tileIdx <= tileIdx + TILE_IDX_W'(1);
                    if (tileIdx == lastTile) begin
                        live <= 1'b0;
                    end
                end else begin
                    pos <= pos + POS_W'(1);
                end
            end
        end
    end

    for (genvar l = 0; l < LAYERS; l++) begin : gLayer
        localparam int B = 6 * l;
        logic go;
        assign go = advance & enLatched[l];
        assign char_addr_out[l]    = go & (pos == POS_W'(B));
        assign char_data_in[l]     = go & (pos == POS_W'(B + 1));
        assign pal_addr_out[l]     = go & (pos == POS_W'(B + 1));
        assign tile_lo_addr_out[l] = go & (pos == POS_W'(B + 2));
        assign tile_lo_data_in[l]  = go & (pos == POS_W'(B + 3));
        assign pal_data_in[l]      = go & (pos == POS_W'(B + 3));
        assign tile_hi_addr_out[l] = go & (pos == POS_W'(B + 4));
        assign tile_hi_data_in[l]  = go & (pos == POS_W'(B + 5));
    end

    assign pixel_out  = advance
                      & (int'(pos) >= SLOT_LEN - PIX_PER_TILE);
    assign tile_index = tileIdx;
    assign busy       = live;
    assign line_done  = lineDoneQ;

endmodule

// File: tb/tb_bg_fetch_sequencer.sv
// Bench for bg_fetch_sequencer: slot table, directed line scenarios,
// and randomized traffic against a cycle-progress reference model.
module tb_bg_fetch_sequencer;

    localparam int SL  = 12;
    localparam int TL  = 40;
    localparam int NL  = 2;
    localparam int PB  = 3;
    localparam int TW  = 7;
    localparam int SLB = 8;
    localparam int TLB = 4;
    localparam int NLB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, line_start, mem_grant;
    logic [NL*PB-1:0] pan_offset;
    logic [NL-1:0] layer_enable;
    logic [NL-1:0] ca, cd, pa, pd, la, ld, ha, hd;
    logic pix, busy, done;
    logic [TW-1:0] tIdx;

    logic resetB, lsB, grantB;
    logic [PB-1:0] panB;
    logic [0:0] enB;
    logic [0:0] caB, cdB, paB, pdB, laB, ldB, haB, hdB;
    logic pixB, busyB, doneB;
    logic [TW-1:0] tIdxB;

    bg_fetch_sequencer #(
        .SLOT_LEN(SL), .TILES_PER_LINE(TL), .LAYERS(NL),
        .PAN_BITS(PB), .TILE_IDX_W(TW)
    ) dutA (
        .clk(clk), .reset(reset), .line_start(line_start),
        .pan_offset(pan_offset), .layer_enable(layer_enable),
        .mem_grant(mem_grant),
        .char_addr_out(ca), .char_data_in(cd),
        .pal_addr_out(pa), .pal_data_in(pd),
        .tile_lo_addr_out(la), .tile_lo_data_in(ld),
        .tile_hi_addr_out(ha), .tile_hi_data_in(hd),
        .pixel_out(pix), .tile_index(tIdx),
        .busy(busy), .line_done(done)
    );

    bg_fetch_sequencer #(
        .SLOT_LEN(SLB), .TILES_PER_LINE(TLB), .LAYERS(NLB),
        .PAN_BITS(PB), .TILE_IDX_W(TW)
    ) dutB (
        .clk(clk), .reset(resetB), .line_start(lsB),
        .pan_offset(panB), .layer_enable(enB),
        .mem_grant(grantB),
        .char_addr_out(caB), .char_data_in(cdB),
        .pal_addr_out(paB), .pal_data_in(pdB),
        .tile_lo_addr_out(laB), .tile_lo_data_in(ldB),
        .tile_hi_addr_out(haB), .tile_hi_data_in(hdB),
        .pixel_out(pixB), .tile_index(tIdxB),
        .busy(busyB), .line_done(doneB)
    );

    typedef struct packed {
        logic [1:0] ca, cd, pa, pd, la, ld, ha, hd;
        logic       pix;
        logic [6:0] tile;
        logic       busy;
        logic       done;
    } obs_t;

    // Model tracks granted cycles k since line start, not pos/tile
    typedef struct {
        bit       live;
        int       k;
        int       total;
        bit [1:0] en;
        bit       done;
    } mdl_t;

    typedef struct {
        bit       grant;
        bit [1:0] ca, cd, pa, pd, la, ld, ha, hd;
        bit       pix;
    } vec_t;

    mdl_t mA, mB;
    int total = 0;
    int passed = 0;
    bit chkOn = 0;
    int pixCnt, strobeCnt, firstAt, doneAt, leak, loAt;
    int busyAtDone;
    vec_t tbl[12];

    function automatic obs_t modelOut(mdl_t m, bit grant,
                                      int slotLen, int layers,
                                      int ppt);
        obs_t o;
        bit adv;
        int p;
        o = '0;
        adv = m.live && grant;
        p = m.k % slotLen;
        o.tile = 7'(m.k / slotLen);
        o.busy = m.live;
        o.done = m.done;
        o.pix = adv && (p >= slotLen - ppt);
        for (int l = 0; l < layers; l++) begin
            if (adv && m.en[l] && p >= 6*l && p < 6*l + 6) begin
                case (p - 6*l)
                    0: o.ca[l] = 1'b1;
                    1: begin o.cd[l] = 1'b1; o.pa[l] = 1'b1; end
                    2: o.la[l] = 1'b1;
                    3: begin o.ld[l] = 1'b1; o.pd[l] = 1'b1; end
                    4: o.ha[l] = 1'b1;
                    default: o.hd[l] = 1'b1;
                endcase
            end
        end
        return o;
    endfunction

    function automatic mdl_t modelStep(mdl_t m, bit rst, bit ls,
                                       bit grant, bit [1:0] en,
                                       bit [5:0] pan, int slotLen,
                                       int tiles, int layers,
                                       int pb);
        mdl_t n;
        bit adv;
        int anyPan;
        n = m;
        adv = m.live && grant;
        anyPan = 0;
        if (rst) begin
            n.live = 0; n.k = 0; n.total = 0;
            n.en = 0; n.done = 0;
            return n;
        end
        n.done = adv && (m.k == m.total - 1) && !ls;
        if (ls) begin
            for (int l = 0; l < layers; l++) begin
                if (en[l] &&
                    ((int'(pan) >> (l*pb)) & ((1 << pb) - 1)) != 0)
                    anyPan = 1;
            end
            n.live = 1; n.k = 0; n.en = en;
            n.total = slotLen * (tiles + anyPan);
        end else if (adv) begin
            n.k = m.k + 1;
            if (n.k == m.total) n.live = 0;
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act,
                       input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0d required=%0d",
                      name, act, exp);
    endtask

    always @(posedge clk) begin
        mA = modelStep(mA, reset, line_start, mem_grant,
                       layer_enable, pan_offset, SL, TL, NL, PB);
        mB = modelStep(mB, resetB, lsB, grantB, {1'b0, enB},
                       {3'b0, panB}, SLB, TLB, NLB, PB);
    end

    always @(negedge clk) begin
        obs_t e, a;
        if (chkOn) begin
            e = modelOut(mA, mem_grant, SL, NL, 8);
            a = {ca, cd, pa, pd, la, ld, ha, hd,
                 pix, tIdx, busy, done};
            total++;
            if (a === e) passed++;
            else $display("FAIL modelA t=%0t actual=%h required=%h",
                          $time, a, e);
            e = modelOut(mB, grantB, SLB, NLB, 8);
            a = {1'b0, caB, 1'b0, cdB, 1'b0, paB, 1'b0, pdB,
                 1'b0, laB, 1'b0, ldB, 1'b0, haB, 1'b0, hdB,
                 pixB, tIdxB, busyB, doneB};
            total++;
            if (a === e) passed++;
            else $display("FAIL modelB t=%0t actual=%h required=%h",
                          $time, a, e);
        end
    end

    task automatic pulseStart();
        line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
    endtask

    task automatic runLine(input int maxCyc, input int stallAt,
                           input int stallLen);
        pulseStart();
        pixCnt = 0; strobeCnt = 0; firstAt = -1; doneAt = -1;
        leak = 0; loAt = -1; busyAtDone = -1;
        for (int c = 0; c < maxCyc && doneAt < 0; c++) begin
            mem_grant = !(c >= stallAt && c < stallAt + stallLen);
            @(negedge clk);
            if (!mem_grant && (pix || |{ca, cd, pa, pd,
                                        la, ld, ha, hd}))
                leak++;
            if (pix) pixCnt++;
            strobeCnt += $countones({ca, cd, pa, pd,
                                     la, ld, ha, hd});
            if (firstAt < 0 && |ca) firstAt = c;
            if (c == stallAt + stallLen && la[0]) loAt = c;
            if (done) begin
                doneAt = c;
                busyAtDone = int'(busy);
            end
            @(posedge clk); #1;
        end
        mem_grant = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 2'b01, 0, 2'b01, 0, 0, 0};
        tbl[4]  = '{1, 0, 0, 0, 0, 0, 0, 2'b01, 0, 1};
        tbl[5]  = '{1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1};
        tbl[6]  = '{1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[7]  = '{1, 0, 2'b10, 2'b10, 0, 0, 0, 0, 0, 1};
        tbl[8]  = '{1, 0, 0, 0, 0, 2'b10, 0, 0, 0, 1};
        tbl[9]  = '{1, 0, 0, 0, 2'b10, 0, 2'b10, 0, 0, 1};
        tbl[10] = '{1, 0, 0, 0, 0, 0, 0, 2'b10, 0, 1};
        tbl[11] = '{1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1};

        reset = 1; line_start = 0; mem_grant = 1;
        pan_offset = '0; layer_enable = 2'b11;
        resetB = 1; lsB = 0; grantB = 1; panB = '0; enB = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0; resetB = 0; chkOn = 1;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_tile", int'(tIdx), 0);
        chk("reset_outs", int'({ca, ha, pix, done}), 0);
        @(posedge clk); #1;

        // Slot 0 strobe table, two layers enabled
        pulseStart();
        for (int i = 0; i < 12; i++) begin
            mem_grant = tbl[i].grant;
            @(negedge clk);
            chk($sformatf("tbl_pos%0d", i),
                int'({ca, cd, pa, pd, la, ld, ha, hd, pix}),
                int'({tbl[i].ca, tbl[i].cd, tbl[i].pa, tbl[i].pd,
                      tbl[i].la, tbl[i].ld, tbl[i].ha, tbl[i].hd,
                      tbl[i].pix}));
            @(posedge clk); #1;
        end

        runLine(600, -100, 0);
        chk("base_first", firstAt, 0);
        chk("base_pix", pixCnt, 320);
        chk("base_strobes", strobeCnt, 640);
        chk("base_done", doneAt, 480);
        chk("base_busy_at_done", busyAtDone, 0);
        chk("base_tile_hold", int'(tIdx), 40);

        pan_offset = 6'b011_000;
        runLine(600, -100, 0);
        chk("pan_pix", pixCnt, 328);
        chk("pan_strobes", strobeCnt, 656);
        chk("pan_done", doneAt, 492);
        chk("pan_tile_hold", int'(tIdx), 41);
        pan_offset = '0;

        runLine(600, 7*12 + 2, 5);
        chk("stall_leak", leak, 0);
        chk("stall_reissue", loAt, 7*12 + 2 + 5);
        chk("stall_pix", pixCnt, 320);
        chk("stall_strobes", strobeCnt, 640);
        chk("stall_done", doneAt, 485);

        layer_enable = 2'b01;
        runLine(600, -100, 0);
        chk("en01_pix", pixCnt, 320);
        chk("en01_strobes", strobeCnt, 320);
        chk("en01_done", doneAt, 480);
        layer_enable = 2'b11;

        runLine(20*12, -100, 0);
        chk("abort_no_done", doneAt, -1);
        runLine(600, -100, 0);
        chk("restart_first", firstAt, 0);
        chk("restart_done", doneAt, 480);

        runLine(100, -100, 0);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_outs", int'({ca, cd, pa, pd, la, ld,
                                  ha, hd, pix, tIdx, done}), 0);
        doneAt = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (done) doneAt++;
        end
        chk("rst_mid_no_done", doneAt, 0);
        @(posedge clk); #1;

        lsB = 1;
        @(posedge clk); #1;
        lsB = 0;
        pixCnt = 0; strobeCnt = 0; doneAt = -1;
        for (int c = 0; c < 60 && doneAt < 0; c++) begin
            @(negedge clk);
            if (c == 0) chk("b_first_char", int'(caB), 1);
            if (pixB) pixCnt++;
            strobeCnt += $countones({caB, cdB, paB, pdB,
                                     laB, ldB, haB, hdB});
            if (doneB) doneAt = c;
            @(posedge clk); #1;
        end
        chk("b_pix", pixCnt, 32);
        chk("b_strobes", strobeCnt, 32);
        chk("b_done", doneAt, 32);

        // Random traffic, both instances against the model
        pulseStart();
        for (int c = 0; c < 6000; c++) begin
            reset        = ($urandom % 1500) == 0;
            line_start   = ($urandom % 700) == 0;
            mem_grant    = ($urandom % 4) != 0;
            layer_enable = 2'($urandom);
            pan_offset   = ($urandom % 3 == 0) ? 6'($urandom) : '0;
            resetB       = ($urandom % 400) == 0;
            lsB          = ($urandom % 60) == 0;
            grantB       = ($urandom % 3) != 0;
            enB          = 1'($urandom);
            panB         = 3'($urandom);
            @(posedge clk); #1;
        end
        reset = 0; line_start = 0; resetB = 0; lsB = 0;
        @(negedge clk);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
